// File: rtl/mem_wr_seq.sv
// ---------------------------------------------------------------------------
// mem_wr_seq
//
// Writeback-side memory write sequencer. Takes a byte-addressed store
// (address, little-endian data, size) from the pipeline and turns it into
// one or two word-aligned, byte-enabled write requests to the data cache.
// A store that straddles a 4-byte word boundary is issued as two back-to-back
// beats. A reserved size, or a straddling store when splitting is disabled,
// is rejected with an error and produces no cache write.
//
// Parameters:
//   ALLOW_SPLIT  1 = split boundary-crossing stores into two beats
//                0 = reject boundary-crossing stores with wr_err
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous, active-high reset
//   wr_valid  in   pipeline presents a store this cycle
//   wr_addr   in   [31:0] byte address of the store
//   wr_data   in   [31:0] store data, byte k goes to wr_addr+k
//   wr_size   in   [1:0]  00=1B, 01=2B, 10=4B, 11=reserved
//   wr_ready  out  sequencer is idle and can take a store
//   dc_req    out  cache write request, held until dc_ack
//   dc_addr   out  [31:0] word-aligned cache address
//   dc_be     out  [3:0]  byte enables for dc_wdata
//   dc_wdata  out  [31:0] lane-aligned write data
//   dc_ack    in   cache accepts the current beat on this edge
//   wr_done   out  one-cycle pulse: store finished or was rejected
//   wr_err    out  qualifies wr_done: the store was rejected
// ---------------------------------------------------------------------------
module mem_wr_seq #(
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_size,
    output logic        wr_ready,
    output logic        dc_req,
    output logic [31:0] dc_addr,
    output logic [3:0]  dc_be,
    output logic [31:0] dc_wdata,
    input  logic        dc_ack,
    output logic        wr_done,
    output logic        wr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;

    // Registered outputs
    logic        ready_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        done_q;
    logic        err_q;

    // Second-beat image captured at accept time, so the beat count and
    // enables never depend on inputs after the store was taken.
    logic        cross_q;
    logic [29:0] word2_q;
    logic [3:0]  be2_q;
    logic [31:0] wdata2_q;

    // Decode of the store currently on the inputs
    logic [1:0]  off_d;
    logic [3:0]  mask_d;
    logic [2:0]  bytes_d;
    logic        size_ok_d;
    logic        cross_d;
    logic        reject_d;
    logic [7:0]  be_wide_d;
    logic [63:0] data_wide_d;

    // Size decode: byte mask and byte count; 11 is reserved.
    always_comb begin
        mask_d    = 4'b0000;
        bytes_d   = 3'd0;
        size_ok_d = 1'b1;
        case (wr_size)
            2'b00: begin
                mask_d  = 4'b0001;
                bytes_d = 3'd1;
            end
            2'b01: begin
                mask_d  = 4'b0011;
                bytes_d = 3'd2;
            end
            2'b10: begin
                mask_d  = 4'b1111;
                bytes_d = 3'd4;
            end
            default: begin
                size_ok_d = 1'b0;
            end
        endcase
    end

    // Shifting the mask and data into a double-width window lines both beats
    // up at once: the low half is the first word, the high half is whatever
    // spilled into the following word.
    assign off_d       = wr_addr[1:0];
    assign cross_d     = (({1'b0, off_d} + bytes_d) > 3'd4);
    assign reject_d    = !size_ok_d || (cross_d && !ALLOW_SPLIT);
    assign be_wide_d   = {4'b0000, mask_d} << off_d;
    assign data_wide_d = {32'h0000_0000, wr_data} << {off_d, 3'b000};

    // Sequencer FSM with all outputs registered. The request stays high from
    // the first beat through the second so the cache sees no bubble between
    // the halves of a split store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            req_q    <= 1'b0;
            addr_q   <= 32'h0000_0000;
            be_q     <= 4'b0000;
            wdata_q  <= 32'h0000_0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cross_q  <= 1'b0;
            word2_q  <= 30'd0;
            be2_q    <= 4'b0000;
            wdata2_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_valid) begin
                        ready_q <= 1'b0;
                        if (reject_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            be_q    <= 4'b0000;
                            wdata_q <= 32'h0000_0000;
                        end else begin
                            state_q  <= BEAT1;
                            req_q    <= 1'b1;
                            addr_q   <= {wr_addr[31:2], 2'b00};
                            be_q     <= be_wide_d[3:0];
                            wdata_q  <= data_wide_d[31:0];
                            cross_q  <= cross_d;
                            word2_q  <= wr_addr[31:2] + 30'd1;
                            be2_q    <= be_wide_d[7:4];
                            wdata2_q <= data_wide_d[63:32];
                        end
                    end
                end

                BEAT1: begin
                    if (dc_ack) begin
                        if (cross_q) begin
                            state_q <= BEAT2;
                            addr_q  <= {word2_q, 2'b00};
                            be_q    <= be2_q;
                            wdata_q <= wdata2_q;
                        end else begin
                            state_q <= DONE;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            be_q    <= 4'b0000;
                            wdata_q <= 32'h0000_0000;
                        end
                    end
                end

                BEAT2: begin
                    if (dc_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        be_q    <= 4'b0000;
                        wdata_q <= 32'h0000_0000;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready = ready_q;
    assign dc_req   = req_q;
    assign dc_addr  = addr_q;
    assign dc_be    = be_q;
    assign dc_wdata = wdata_q;
    assign wr_done  = done_q;
    assign wr_err   = err_q;

endmodule

// File: tb/tb_mem_wr_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_wr_seq
//
// Directed bench for mem_wr_seq. Two instances: dut0 splits crossing stores,
// dut1 rejects them. Expected cache beats and completions are queued when a
// store is issued; monitors pop and compare whenever a beat is acked or
// wr_done pulses.
// ---------------------------------------------------------------------------
module tb_mem_wr_seq;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        dcAck;
   logic [31:0] wrAddr;
   logic [31:0] wrData;
   logic [1:0]  wrSize;

   logic        wrValid0, wrReady0, dcReq0, wrDone0, wrErr0;
   logic [31:0] dcAddr0, dcWdata0;
   logic [3:0]  dcBe0;

   logic        wrValid1, wrReady1, dcReq1, wrDone1, wrErr1;
   logic [31:0] dcAddr1, dcWdata1;
   logic [3:0]  dcBe1;

   beat_t beatQ[$];
   bit    doneQ0[$];
   bit    doneQ1[$];

   int total = 0;
   int bad   = 0;

   mem_wr_seq #(.ALLOW_SPLIT(1'b1)) dut0 (
      .clk(clk), .rst(rst),
      .wr_valid(wrValid0), .wr_addr(wrAddr), .wr_data(wrData), .wr_size(wrSize),
      .wr_ready(wrReady0), .dc_req(dcReq0), .dc_addr(dcAddr0), .dc_be(dcBe0),
      .dc_wdata(dcWdata0), .dc_ack(dcAck), .wr_done(wrDone0), .wr_err(wrErr0)
   );

   mem_wr_seq #(.ALLOW_SPLIT(1'b0)) dut1 (
      .clk(clk), .rst(rst),
      .wr_valid(wrValid1), .wr_addr(wrAddr), .wr_data(wrData), .wr_size(wrSize),
      .wr_ready(wrReady1), .dc_req(dcReq1), .dc_addr(dcAddr1), .dc_be(dcBe1),
      .dc_wdata(dcWdata1), .dc_ack(dcAck), .wr_done(wrDone1), .wr_err(wrErr1)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=no_finish want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expectBeat(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
      beat_t e;
      e.addr = a;
      e.be   = b;
      e.data = d;
      beatQ.push_back(e);
   endtask

   // Wait (bounded) until the selected instance is idle and ready
   task automatic waitReady(input int sel);
      int n;
      n = 0;
      @(negedge clk);
      while (((sel == 0) ? !wrReady0 : !wrReady1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ready_timeout", (sel == 0) ? wrReady0 : wrReady1, 1);
   endtask

   // Present one store; returns 1 ns after the accepting edge
   task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] s);
      waitReady(sel);
      wrAddr = a;
      wrData = d;
      wrSize = s;
      if (sel == 0) wrValid0 = 1'b1;
      else          wrValid1 = 1'b1;
      @(posedge clk);
      #1;
      wrValid0 = 1'b0;
      wrValid1 = 1'b0;
   endtask

   // Scoreboard monitor for dut0: every acked beat and every done pulse
   // must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (dcReq0 && dcAck) begin
            if (beatQ.size() == 0) begin
               checkOutput("unexpected_beat_addr", dcAddr0, 32'hxxxx_xxxx);
            end else begin
               beat_t e;
               e = beatQ.pop_front();
               checkOutput("beat_addr", dcAddr0, e.addr);
               checkOutput("beat_be", {28'd0, dcBe0}, {28'd0, e.be});
               checkOutput("beat_wdata", dcWdata0, e.data);
            end
         end
         if (wrDone0) begin
            if (doneQ0.size() == 0) begin
               checkOutput("unexpected_done0", {31'd0, wrDone0}, 0);
            end else begin
               checkOutput("done0_err", {31'd0, wrErr0}, {31'd0, doneQ0.pop_front()});
            end
         end
      end
   end

   // Monitor for dut1: it never writes the cache in this bench
   always @(negedge clk) begin
      if (!rst) begin
         if (dcReq1) checkOutput("dut1_req", {31'd0, dcReq1}, 0);
         if (wrDone1) begin
            if (doneQ1.size() == 0) begin
               checkOutput("unexpected_done1", {31'd0, wrDone1}, 0);
            end else begin
               checkOutput("done1_err", {31'd0, wrErr1}, {31'd0, doneQ1.pop_front()});
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      dcAck    = 1'b1;
      wrValid0 = 1'b0;
      wrValid1 = 1'b0;
      wrAddr   = '0;
      wrData   = '0;
      wrSize   = '0;

      // Reset state
      #12;
      checkOutput("rst_ready", {31'd0, wrReady0}, 1);
      checkOutput("rst_req", {31'd0, dcReq0}, 0);
      checkOutput("rst_addr", dcAddr0, 0);
      checkOutput("rst_be", {28'd0, dcBe0}, 0);
      checkOutput("rst_wdata", dcWdata0, 0);
      checkOutput("rst_done", {31'd0, wrDone0}, 0);
      checkOutput("rst_err", {31'd0, wrErr0}, 0);
      @(posedge clk);
      #2 rst = 1'b0;

      // 4B aligned, ack tied high: beat in N+1, done in N+2, ready in N+3
      $display("[TB] 4B aligned");
      expectBeat(32'h0000_1000, 4'b1111, 32'hAABB_CCDD);
      doneQ0.push_back(1'b0);
      applyStimulus(0, 32'h0000_1000, 32'hAABB_CCDD, 2'b10);
      @(negedge clk);
      checkOutput("al_req_n1", {31'd0, dcReq0}, 1);
      checkOutput("al_ready_n1", {31'd0, wrReady0}, 0);
      @(negedge clk);
      checkOutput("al_done_n2", {31'd0, wrDone0}, 1);
      checkOutput("al_req_n2", {31'd0, dcReq0}, 0);
      checkOutput("al_be_n2", {28'd0, dcBe0}, 0);
      @(negedge clk);
      checkOutput("al_ready_n3", {31'd0, wrReady0}, 1);
      checkOutput("al_done_n3", {31'd0, wrDone0}, 0);

      // 4B crossing at offset 3, request continuous across both beats
      $display("[TB] 4B crossing");
      expectBeat(32'h0000_1000, 4'b1000, 32'h4400_0000);
      expectBeat(32'h0000_1004, 4'b0111, 32'h0011_2233);
      doneQ0.push_back(1'b0);
      applyStimulus(0, 32'h0000_1003, 32'h1122_3344, 2'b10);
      @(negedge clk);
      checkOutput("cr_req_b1", {31'd0, dcReq0}, 1);
      @(negedge clk);
      checkOutput("cr_req_b2", {31'd0, dcReq0}, 1);
      @(negedge clk);
      checkOutput("cr_done", {31'd0, wrDone0}, 1);
      checkOutput("cr_req_off", {31'd0, dcReq0}, 0);

      // 2B at offset 2 (single beat), 2B at offset 3 (split), 1B at offset 3
      $display("[TB] 2B/1B offsets");
      expectBeat(32'h0000_2000, 4'b1100, 32'hBEEF_0000);
      doneQ0.push_back(1'b0);
      applyStimulus(0, 32'h0000_2002, 32'h0000_BEEF, 2'b01);
      expectBeat(32'h0000_2000, 4'b1000, 32'hEF00_0000);
      expectBeat(32'h0000_2004, 4'b0001, 32'h0000_00BE);
      doneQ0.push_back(1'b0);
      applyStimulus(0, 32'h0000_2003, 32'h0000_BEEF, 2'b01);
      expectBeat(32'h0000_4000, 4'b1000, 32'hA500_0000);
      doneQ0.push_back(1'b0);
      applyStimulus(0, 32'h0000_4003, 32'h0000_00A5, 2'b00);

      // Address wrap at the top of memory
      $display("[TB] wrap");
      expectBeat(32'hFFFF_FFFC, 4'b1100, 32'hF00D_0000);
      expectBeat(32'h0000_0000, 4'b0011, 32'h0000_CAFE);
      doneQ0.push_back(1'b0);
      applyStimulus(0, 32'hFFFF_FFFE, 32'hCAFE_F00D, 2'b10);

      // Backpressure: ack low for several cycles, stray wr_valid ignored
      $display("[TB] backpressure");
      waitReady(0);
      @(posedge clk);
      #1 dcAck = 1'b0;
      expectBeat(32'h0000_3000, 4'b1111, 32'h1234_5678);
      doneQ0.push_back(1'b0);
      applyStimulus(0, 32'h0000_3000, 32'h1234_5678, 2'b10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_req", {31'd0, dcReq0}, 1);
         checkOutput("bp_addr", dcAddr0, 32'h0000_3000);
         checkOutput("bp_be", {28'd0, dcBe0}, 32'h0000_000F);
         checkOutput("bp_wdata", dcWdata0, 32'h1234_5678);
         checkOutput("bp_ready", {31'd0, wrReady0}, 0);
         wrValid0 = (i % 2 == 0);
         wrAddr   = 32'h0000_3001;
         wrData   = 32'hDEAD_BEEF;
      end
      wrValid0 = 1'b0;
      @(posedge clk);
      #1 dcAck = 1'b1;

      // Reserved size: no cache request, error completion
      $display("[TB] reserved size");
      doneQ0.push_back(1'b1);
      applyStimulus(0, 32'h0000_5000, 32'h0102_0304, 2'b11);
      @(negedge clk);
      checkOutput("rs_req", {31'd0, dcReq0}, 0);
      checkOutput("rs_done", {31'd0, wrDone0}, 1);
      checkOutput("rs_err", {31'd0, wrErr0}, 1);

      // Splitting disabled: crossing store rejected on dut1
      $display("[TB] no-split reject");
      doneQ1.push_back(1'b1);
      applyStimulus(1, 32'h0000_1003, 32'h1122_3344, 2'b10);
      @(negedge clk);
      checkOutput("ns_req", {31'd0, dcReq1}, 0);
      checkOutput("ns_done", {31'd0, wrDone1}, 1);
      checkOutput("ns_err", {31'd0, wrErr1}, 1);

      // Reset in the middle of the second beat
      $display("[TB] reset in beat2");
      expectBeat(32'h0000_1000, 4'b1000, 32'h4400_0000);
      applyStimulus(0, 32'h0000_1003, 32'h1122_3344, 2'b10);
      @(posedge clk);
      #1 dcAck = 1'b0;
      @(negedge clk);
      checkOutput("rb_req_b2", {31'd0, dcReq0}, 1);
      checkOutput("rb_addr_b2", dcAddr0, 32'h0000_1004);
      #1 rst = 1'b1;
      #1;
      checkOutput("rb_req_rst", {31'd0, dcReq0}, 0);
      checkOutput("rb_ready_rst", {31'd0, wrReady0}, 1);
      @(posedge clk);
      #2 rst = 1'b0;
      dcAck = 1'b1;
      @(negedge clk);
      checkOutput("rb_ready_rel", {31'd0, wrReady0}, 1);
      checkOutput("rb_req_rel", {31'd0, dcReq0}, 0);
      checkOutput("rb_done_rel", {31'd0, wrDone0}, 0);

      // Every queued expectation must have been consumed
      repeat (3) @(negedge clk);
      checkOutput("beatq_empty", beatQ.size(), 0);
      checkOutput("doneq0_empty", doneQ0.size(), 0);
      checkOutput("doneq1_empty", doneQ1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
